// File: rtl/axi4_lite_master_fsm_if.sv
// AXI4-Lite bus bundle between the command-driven master and its slave.
// The master modport drives AR/AW/W valids and payloads plus R/B readies.
interface axi4_lite_master_fsm_if #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                      arvalid;
  logic                      arready;
  logic [ADDR_WIDTH-1:0]     araddr;
  logic                      rvalid;
  logic                      rready;
  logic [DATA_WIDTH-1:0]     rdata;
  logic [1:0]                rresp;
  logic                      awvalid;
  logic                      awready;
  logic [ADDR_WIDTH-1:0]     awaddr;
  logic                      wvalid;
  logic                      wready;
  logic [DATA_WIDTH-1:0]     wdata;
  logic [DATA_WIDTH/8-1:0]   wstrb;
  logic                      bvalid;
  logic                      bready;
  logic [1:0]                bresp;

  modport master (
    output arvalid, araddr, rready, awvalid, awaddr, wvalid, wdata, wstrb, bready,
    input  arready, rvalid, rdata, rresp, awready, wready, bvalid, bresp
  );

  modport slave (
    input  arvalid, araddr, rready, awvalid, awaddr, wvalid, wdata, wstrb, bready,
    output arready, rvalid, rdata, rresp, awready, wready, bvalid, bresp
  );
endinterface

// File: rtl/axi4_lite_master_fsm.sv
// Single-outstanding AXI4-Lite master: turns a one-beat read/write command
// into an AXI4-Lite transaction and returns a one-cycle response strobe.
// Optional watchdog enabled by defining AXI4_MASTER_TIMEOUT_EN.
// All outputs come from registered state; no input-to-output paths.
module axi4_lite_master_fsm #(
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_cmd_valid,
  output logic                    o_cmd_ready,
  input  logic                    i_cmd_write,
  input  logic [ADDR_WIDTH-1:0]   i_cmd_addr,
  input  logic [DATA_WIDTH-1:0]   i_cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_cmd_wstrb,
  output logic                    o_rsp_valid,
  output logic [DATA_WIDTH-1:0]   o_rsp_rdata,
  output logic [1:0]              o_rsp_resp,
`ifdef AXI4_MASTER_TIMEOUT_EN
  output logic                    o_timeout,
`endif
  axi4_lite_master_fsm_if.master  m_axi
);

  if ((DATA_WIDTH != 32 && DATA_WIDTH != 64) || TIMEOUT_CYCLES == 0) begin : g_param_check
    $error("axi4_lite_master_fsm: DATA_WIDTH must be 32/64, TIMEOUT_CYCLES nonzero");
  end

  typedef enum logic [2:0] {
    StIdle, StRdAddr, StRdData, StWrReq, StWrResp, StDone
  } state_e;

  state_e                  r_state, w_state_d;
  logic [ADDR_WIDTH-1:0]   r_addr, w_addr_d;
  logic [DATA_WIDTH-1:0]   r_wdata, w_wdata_d;
  logic [DATA_WIDTH/8-1:0] r_wstrb, w_wstrb_d;
  logic                    r_aw_done, w_aw_done_d;
  logic                    r_w_done, w_w_done_d;
  logic [DATA_WIDTH-1:0]   r_rsp_rdata, w_rsp_rdata_d;
  logic [1:0]              r_rsp_resp, w_rsp_resp_d;
  logic                    w_aw_fire, w_w_fire, w_accept;

  // Outputs decoded purely from registered state.
  assign o_cmd_ready   = (r_state == StIdle);
  assign o_rsp_valid   = (r_state == StDone);
  assign o_rsp_rdata   = r_rsp_rdata;
  assign o_rsp_resp    = r_rsp_resp;
  assign m_axi.arvalid = (r_state == StRdAddr);
  assign m_axi.araddr  = r_addr;
  assign m_axi.rready  = (r_state == StRdData);
  // AW and W are retired independently so either order or both at once works.
  assign m_axi.awvalid = (r_state == StWrReq) && !r_aw_done;
  assign m_axi.awaddr  = r_addr;
  assign m_axi.wvalid  = (r_state == StWrReq) && !r_w_done;
  assign m_axi.wdata   = r_wdata;
  assign m_axi.wstrb   = r_wstrb;
  assign m_axi.bready  = (r_state == StWrResp);

  assign w_aw_fire = m_axi.awvalid && m_axi.awready;
  assign w_w_fire  = m_axi.wvalid && m_axi.wready;
  assign w_accept  = (r_state == StIdle) && i_cmd_valid;

  // Next-state, payload capture and handshake tracking.
  always_comb begin
    w_state_d      = r_state;
    w_addr_d       = r_addr;
    w_wdata_d      = r_wdata;
    w_wstrb_d      = r_wstrb;
    w_aw_done_d    = r_aw_done;
    w_w_done_d     = r_w_done;
    w_rsp_rdata_d  = r_rsp_rdata;
    w_rsp_resp_d   = r_rsp_resp;
    case (r_state)
      StIdle: begin
        if (i_cmd_valid) begin
          w_addr_d    = i_cmd_addr;
          w_wdata_d   = i_cmd_wdata;
          w_wstrb_d   = i_cmd_wstrb;
          w_aw_done_d = 1'b0;
          w_w_done_d  = 1'b0;
          w_state_d   = i_cmd_write ? StWrReq : StRdAddr;
        end
      end
      StRdAddr: begin
        if (m_axi.arready) w_state_d = StRdData;
      end
      StRdData: begin
        if (m_axi.rvalid) begin
          w_rsp_rdata_d = m_axi.rdata;
          w_rsp_resp_d  = m_axi.rresp;
          w_state_d     = StDone;
        end
      end
      StWrReq: begin
        w_aw_done_d = r_aw_done || w_aw_fire;
        w_w_done_d  = r_w_done || w_w_fire;
        if (w_aw_done_d && w_w_done_d) begin
          w_aw_done_d = 1'b0;
          w_w_done_d  = 1'b0;
          w_state_d   = StWrResp;
        end
      end
      StWrResp: begin
        if (m_axi.bvalid) begin
          w_rsp_resp_d = m_axi.bresp;
          w_state_d    = StDone;
        end
      end
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_aw_done   <= 1'b0;
      r_w_done    <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_resp  <= '0;
    end else begin
      r_state     <= w_state_d;
      r_addr      <= w_addr_d;
      r_wdata     <= w_wdata_d;
      r_wstrb     <= w_wstrb_d;
      r_aw_done   <= w_aw_done_d;
      r_w_done    <= w_w_done_d;
      r_rsp_rdata <= w_rsp_rdata_d;
      r_rsp_resp  <= w_rsp_resp_d;
    end
  end

`ifdef AXI4_MASTER_TIMEOUT_EN
  localparam int unsigned CntWidth = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntWidth-1:0] CntMax = CntWidth'(TIMEOUT_CYCLES);

  logic [CntWidth-1:0] r_to_cnt;
  logic                r_timeout;
  logic                w_busy;

  assign w_busy    = (r_state == StRdAddr) || (r_state == StRdData) ||
                     (r_state == StWrReq)  || (r_state == StWrResp);
  assign o_timeout = r_timeout;

  // Watchdog: counts busy cycles, saturates at the limit, flag is sticky.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_to_cnt  <= '0;
      r_timeout <= 1'b0;
    end else if (w_accept) begin
      r_to_cnt  <= '0;
      r_timeout <= 1'b0;
    end else if (w_busy && (r_to_cnt != CntMax)) begin
      r_to_cnt <= r_to_cnt + 1'b1;
      if (r_to_cnt == CntMax - 1'b1) r_timeout <= 1'b1;
    end
  end
`else
  // Watchdog not built; the accept strobe has no other consumer.
  logic w_unused_accept;
  assign w_unused_accept = w_accept;
`endif

endmodule

// File: tb/tb_axi4_lite_master_fsm.sv
// Directed bench for axi4_lite_master_fsm; the bench plays the slave by hand.
module tb_axi4_lite_master_fsm;
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0]   cmd_addr;
  logic [DW-1:0]   cmd_wdata;
  logic [DW/8-1:0] cmd_wstrb;
  logic            rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic [1:0]      rsp_resp;
`ifdef AXI4_MASTER_TIMEOUT_EN
  logic            timeout;
`endif

  int n_checks = 0;
  int n_errors = 0;

  axi4_lite_master_fsm_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi_if ();

  axi4_lite_master_fsm #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_cmd_valid (cmd_valid),
    .o_cmd_ready (cmd_ready),
    .i_cmd_write (cmd_write),
    .i_cmd_addr  (cmd_addr),
    .i_cmd_wdata (cmd_wdata),
    .i_cmd_wstrb (cmd_wstrb),
    .o_rsp_valid (rsp_valid),
    .o_rsp_rdata (rsp_rdata),
    .o_rsp_resp  (rsp_resp),
`ifdef AXI4_MASTER_TIMEOUT_EN
    .o_timeout   (timeout),
`endif
    .m_axi       (axi_if)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; everything after this is sampled/driven 1 ns past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [DW/8-1:0] s);
    check_eq("cmd_ready_before_accept", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    step();
    cmd_valid = 1'b0; cmd_addr = '1; cmd_wdata = '1; cmd_wstrb = '1;
  endtask

  initial begin
    rst = 1'b1;
    cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    axi_if.arready = 0; axi_if.rvalid = 0; axi_if.rdata = '0; axi_if.rresp = '0;
    axi_if.awready = 0; axi_if.wready = 0; axi_if.bvalid = 0; axi_if.bresp = '0;
    step(); step();
    check_eq("rst_arvalid", axi_if.arvalid, 0);
    check_eq("rst_awvalid", axi_if.awvalid, 0);
    check_eq("rst_wvalid", axi_if.wvalid, 0);
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_rsp_rdata", rsp_rdata, 0);
    check_eq("rst_rsp_resp", rsp_resp, 0);
    rst = 1'b0;
    check_eq("post_rst_cmd_ready", cmd_ready, 1);

    // Reset in the middle of a read: ARVALID must drop without a clock edge.
    issue(1'b0, 8'h20, '0, '0);
    check_eq("midrd_arvalid", axi_if.arvalid, 1);
    check_eq("midrd_araddr", axi_if.araddr, 8'h20);
    #2 rst = 1'b1;
    #1 check_eq("midrd_async_arvalid", axi_if.arvalid, 0);
    step();
    rst = 1'b0;
    axi_if.arready = 1; axi_if.rvalid = 1;
    check_eq("midrd_cmd_ready", cmd_ready, 1);
    for (int i = 0; i < 2; i++) begin
      check_eq("midrd_no_rready", axi_if.rready, 0);
      check_eq("midrd_no_rsp", rsp_valid, 0);
      step();
    end
    axi_if.rvalid = 0;

    // Read against an always-ready slave: rsp_valid three cycles after accept.
    axi_if.arready = 1; axi_if.rvalid = 1; axi_if.rdata = 32'hCAFEF00D; axi_if.rresp = 2'b00;
    issue(1'b0, 8'h04, '0, '0);
    check_eq("rd_arvalid_c1", axi_if.arvalid, 1);
    check_eq("rd_araddr_c1", axi_if.araddr, 8'h04);
    check_eq("rd_rsp_c1", rsp_valid, 0);
    step();
    check_eq("rd_rready_c2", axi_if.rready, 1);
    check_eq("rd_arvalid_c2", axi_if.arvalid, 0);
    step();
    check_eq("rd_rsp_valid_c3", rsp_valid, 1);
    check_eq("rd_rdata_c3", rsp_rdata, 32'hCAFEF00D);
    check_eq("rd_resp_c3", rsp_resp, 0);
    check_eq("rd_cmd_ready_c3", cmd_ready, 0);
    step();
    check_eq("rd_rsp_pulse_end", rsp_valid, 0);
    axi_if.arready = 0; axi_if.rvalid = 0; axi_if.rdata = 32'h11111111;

    // Write, WREADY only after AW has been accepted.
    issue(1'b1, 8'h10, 32'hDEADBEEF, 4'hF);
    check_eq("seqwr_awvalid_c1", axi_if.awvalid, 1);
    check_eq("seqwr_wvalid_c1", axi_if.wvalid, 1);
    check_eq("seqwr_awaddr_c1", axi_if.awaddr, 8'h10);
    check_eq("seqwr_wdata_c1", axi_if.wdata, 32'hDEADBEEF);
    check_eq("seqwr_wstrb_c1", axi_if.wstrb, 4'hF);
    axi_if.awready = 1;
    step();
    check_eq("seqwr_awvalid_c2", axi_if.awvalid, 0);
    check_eq("seqwr_wvalid_c2", axi_if.wvalid, 1);
    check_eq("seqwr_wdata_c2", axi_if.wdata, 32'hDEADBEEF);
    check_eq("seqwr_bready_c2", axi_if.bready, 0);
    axi_if.awready = 0; axi_if.wready = 1;
    step();
    check_eq("seqwr_wvalid_c3", axi_if.wvalid, 0);
    check_eq("seqwr_bready_c3", axi_if.bready, 1);
    axi_if.wready = 0; axi_if.bvalid = 1; axi_if.bresp = 2'b00;
    step();
    check_eq("seqwr_rsp_valid", rsp_valid, 1);
    check_eq("seqwr_rsp_resp", rsp_resp, 0);
    check_eq("seqwr_rdata_kept", rsp_rdata, 32'hCAFEF00D);
    axi_if.bvalid = 0;
    step();

    // Write with AW and W accepted in the same cycle.
    issue(1'b1, 8'h14, 32'h12345678, 4'h3);
    axi_if.awready = 1; axi_if.wready = 1;
    step();
    check_eq("simwr_bready", axi_if.bready, 1);
    check_eq("simwr_no_dup_aw", axi_if.awvalid, 0);
    check_eq("simwr_no_dup_w", axi_if.wvalid, 0);
    axi_if.awready = 0; axi_if.wready = 0; axi_if.bvalid = 1; axi_if.bresp = 2'b11;
    step();
    check_eq("simwr_rsp_valid", rsp_valid, 1);
    check_eq("simwr_decerr", rsp_resp, 2'b11);
    axi_if.bvalid = 0;
    step();

    // Write where W completes before AW.
    issue(1'b1, 8'h18, 32'hA5A5A5A5, 4'h5);
    axi_if.wready = 1;
    step();
    check_eq("wfirst_wvalid", axi_if.wvalid, 0);
    check_eq("wfirst_awvalid", axi_if.awvalid, 1);
    check_eq("wfirst_awaddr", axi_if.awaddr, 8'h18);
    axi_if.wready = 0; axi_if.awready = 1;
    step();
    check_eq("wfirst_bready", axi_if.bready, 1);
    axi_if.awready = 0; axi_if.bvalid = 1; axi_if.bresp = 2'b10;
    step();
    check_eq("wfirst_slverr", rsp_resp, 2'b10);
    axi_if.bvalid = 0;
    step();

    // Read with RVALID held off for five cycles, then SLVERR.
    axi_if.arready = 1;
    issue(1'b0, 8'h08, '0, '0);
    step();
    axi_if.arready = 0;
    for (int i = 0; i < 5; i++) begin
      check_eq("bp_rready_hold", axi_if.rready, 1);
      check_eq("bp_cmd_ready_low", cmd_ready, 0);
      check_eq("bp_no_rsp", rsp_valid, 0);
      step();
    end
    axi_if.rvalid = 1; axi_if.rdata = 32'h0BADF00D; axi_if.rresp = 2'b10;
    check_eq("bp_rready_last", axi_if.rready, 1);
    step();
    axi_if.rvalid = 0;
    check_eq("bp_rsp_valid", rsp_valid, 1);
    check_eq("bp_rsp_resp", rsp_resp, 2'b10);
    check_eq("bp_rsp_rdata", rsp_rdata, 32'h0BADF00D);
    check_eq("bp_cmd_ready_done", cmd_ready, 0);
    step();
    check_eq("bp_cmd_ready_after", cmd_ready, 1);

`ifdef AXI4_MASTER_TIMEOUT_EN
    // Slave never raises ARREADY: flag sets once 8 wait cycles have elapsed.
    issue(1'b0, 8'h30, '0, '0);
    for (int i = 1; i < 8; i++) step();
    check_eq("to_not_yet", timeout, 0);
    step();
    check_eq("to_set", timeout, 1);
    check_eq("to_arvalid_held", axi_if.arvalid, 1);
    step();
    check_eq("to_sticky", timeout, 1);
    rst = 1'b1;
    #1 check_eq("to_rst_clear", timeout, 0);
    step();
    rst = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/axi4_lite_master_fsm.md
Name: axi4_lite_master_fsm

Overview:
- Single-outstanding AXI4-Lite master. Converts a simple command handshake (read or write, one beat) into AXI4-Lite transactions.
- Sits directly upstream of the RAM's AXI4-Lite slave FSM and drives its five channels.
- Returns read data and response status to the requester as a one-cycle response strobe.
- Tolerates slaves that raise WREADY only after the address is accepted, and slaves that accept AW and W together.

Parameters:
- ADDR_WIDTH, 8, width of cmd_addr, AWADDR and ARADDR.
- DATA_WIDTH, 32, width of the data buses; must be 32 or 64.
- TIMEOUT_CYCLES, 255, watchdog limit; used only with AXI4_MASTER_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  master can accept a command.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  byte address.
- cmd_wdata  in  DATA_WIDTH  write data.
- cmd_wstrb  in  DATA_WIDTH/8  write byte strobes.
- rsp_valid  out  1  one-cycle pulse: transaction complete.
- rsp_rdata  out  DATA_WIDTH  read data; holds last value.
- rsp_resp  out  2  captured RRESP or BRESP.
- ARVALID out 1; ARREADY in 1; ARADDR out ADDR_WIDTH.
- RVALID in 1; RREADY out 1; RDATA in DATA_WIDTH; RRESP in 2.
- AWVALID out 1; AWREADY in 1; AWADDR out ADDR_WIDTH.
- WVALID out 1; WREADY in 1; WDATA out DATA_WIDTH; WSTRB out DATA_WIDTH/8.
- BVALID in 1; BREADY out 1; BRESP in 2.
- timeout  out  1  sticky watchdog flag; present only with AXI4_MASTER_TIMEOUT_EN.

Behaviour:
Reset:
- rst asynchronously forces IDLE, including mid-transaction.
- All AXI valid/ready outputs, rsp_valid and timeout go to 0. Address, data and strobe registers, rsp_rdata and rsp_resp go to 0.
- cmd_ready goes to 1 in the first cycle after rst deasserts.
- A transaction in flight at reset is abandoned; no response is produced.

All outputs are registered or decoded from registered state only. There is no combinational path from any input to any output.

States:
- IDLE
  - cmd_ready = 1.
  - On cmd_valid: capture addr/wdata/wstrb.
  - cmd_write = 0 -> RD_ADDR; cmd_write = 1 -> WR_REQ.
  - ARVALID (read) or AWVALID and WVALID (write) are high in the next cycle.
- RD_ADDR
  - ARVALID = 1, ARADDR held stable.
  - On ARREADY -> RD_DATA.
- RD_DATA
  - RREADY = 1.
  - On RVALID: capture RDATA into rsp_rdata and RRESP into rsp_resp -> DONE.
- WR_REQ
  - AWVALID = 1 until the AW handshake completes. WVALID = 1 until the W handshake completes. The two are tracked independently with aw_done and w_done flags.
  - Handshakes may occur in the same cycle or in either order.
  - AWADDR, WDATA and WSTRB are held stable throughout.
  - When both are done (including completion in the same cycle) -> WR_RESP.
- WR_RESP
  - BREADY = 1.
  - On BVALID: capture BRESP into rsp_resp -> DONE. rsp_rdata is unchanged.
- DONE
  - rsp_valid = 1 for exactly this cycle; cmd_ready = 0.
  - -> IDLE unconditionally.
- Any undefined state encoding -> IDLE.

Timing:
- Minimum read latency, with a slave that is always ready: cmd accept at cycle 0, ARVALID at 1, RREADY at 2, rsp_valid at 3.
- Writes against a slave that raises WREADY only after AW is accepted add one cycle per serialised handshake.
- Back-to-back: a new command is accepted at the earliest one cycle after rsp_valid.

Protocol rules:
- Once asserted, a VALID stays high until its handshake completes, and its payload does not change.
- The requester must hold cmd_* stable only for the cmd_valid && cmd_ready cycle.
- SLVERR and DECERR are passed through on rsp_resp; no retry.

Optional Feature:
- Macro: AXI4_MASTER_TIMEOUT_EN.
- When defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on command accept and increments each cycle in RD_ADDR, RD_DATA, WR_REQ and WR_RESP.
  - When it reaches TIMEOUT_CYCLES, the timeout output sets and stays set.
  - The FSM keeps waiting; VALIDs are never dropped.
  - timeout clears on the next command accept or on rst.
- When undefined: no counter, no timeout port, and behaviour is otherwise identical.

Test Plan:
- Reset mid-read: assert rst while ARVALID = 1 -> ARVALID falls with no clock edge. After release, cmd_ready = 1, rsp_valid = 0, and no RREADY appears.
- Read, slave always ready: read from 0x04, slave returns RDATA = 0xCAFEF00D, RRESP = 0 -> ARADDR = 0x04, and rsp_valid pulses at cycle 3 with rsp_rdata = 0xCAFEF00D, rsp_resp = 0.
- Write, sequential slave (WREADY only after AW): write 0xDEADBEEF to 0x10 with wstrb = 0xF -> AWVALID and WVALID both rise. WVALID holds with stable WDATA through the AW handshake until WREADY. BREADY follows; BRESP = 0 gives rsp_valid with rsp_resp = 0, and rsp_rdata is unchanged.
- Write, simultaneous handshake: AWREADY and WREADY both high in the same cycle -> WR_RESP is reached in the next cycle. No duplicate AWVALID or WVALID is issued.
- Error and backpressure: slave delays RVALID by 5 cycles, then returns RRESP = 2'b10 -> RREADY stays high throughout, rsp_resp = 2'b10, and cmd_ready = 0 until the cycle after rsp_valid.
- Timeout (macro defined, TIMEOUT_CYCLES = 8): slave never asserts ARREADY -> timeout = 1 at the 8th wait cycle and ARVALID remains high. After reset, timeout = 0.
